// File: rtl/chacha20_stream_engine.sv
// ChaCha20 stream engine: generates consecutive keystream blocks with an
// auto-incrementing block counter and XORs them onto a valid/ready stream.
// Four quarter-round lanes run in parallel, giving one full round per cycle.

// One ChaCha quarter-round, purely combinational.
module chacha20_qr (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [31:0] c_o,
  output logic [31:0] d_o
);
  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  logic [31:0] a1, b1, c1, d1;
  assign a1  = a + b;
  assign d1  = rotl(d ^ a1, 16);
  assign c1  = c + d1;
  assign b1  = rotl(b ^ c1, 12);
  assign a_o = a1 + b1;
  assign d_o = rotl(d1 ^ a_o, 8);
  assign c_o = c1 + d_o;
  assign b_o = rotl(b1 ^ c_o, 7);
endmodule

module chacha20_stream_engine #(
  parameter int ROUNDS = 20,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err_ctr_wrap,
  input  logic [255:0]      in_key,
  input  logic [95:0]       in_nonce,
  input  logic [31:0]       in_counter,
  input  logic [15:0]       num_blocks,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);
  localparam int BEATS = 512 / DATA_W;

  if (!(ROUNDS == 8 || ROUNDS == 12 || ROUNDS == 20)) begin : g_bad_rounds
    $error("chacha20_stream_engine: ROUNDS must be 8, 12 or 20");
  end
  if (!(DATA_W == 32 || DATA_W == 64 || DATA_W == 128 || DATA_W == 256 || DATA_W == 512)) begin : g_bad_width
    $error("chacha20_stream_engine: DATA_W must be 32, 64, 128, 256 or 512");
  end

  typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, STREAM, DONE} state_t;

  function automatic logic [31:0] le32(input logic [31:0] be);
    return {be[7:0], be[15:8], be[23:16], be[31:24]};
  endfunction

  state_t            state;
  logic [255:0]      key;
  logic [95:0]       nonce;
  logic [31:0]       ctr;
  logic [15:0]       blocks_left;   // blocks still owed, including the one in progress
  logic [4:0]        rnd;
  logic [4:0]        beat;
  logic [15:0][31:0] ws;            // working state; holds the keystream after FINAL
  logic [15:0][31:0] init_st;
  logic [15:0][31:0] init_vec;
  logic [15:0][31:0] nxt;
  logic [3:0][31:0]  qa, qb, qc, qd, ra, rb, rc, rd;
  logic [511:0]      ks;
  logic [DATA_W-1:0] slice;
  logic              diag, xfer, last_beat, more;

  assign diag      = rnd[0];
  assign ks        = ws;
  assign slice     = ks[beat*DATA_W +: DATA_W];
  assign s_ready   = (state == STREAM) && (!m_valid || m_ready);
  assign xfer      = s_valid && s_ready;
  assign last_beat = (beat == 5'(BEATS - 1));
  assign more      = (blocks_left != 16'd1);

  // Quarter-round lanes: column words on even rounds, diagonals on odd rounds.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign qa[i] = ws[i];
    assign qb[i] = diag ? ws[4 + (i + 1) % 4]  : ws[4 + i];
    assign qc[i] = diag ? ws[8 + (i + 2) % 4]  : ws[8 + i];
    assign qd[i] = diag ? ws[12 + (i + 3) % 4] : ws[12 + i];
    chacha20_qr u_qr (
      .a(qa[i]), .b(qb[i]), .c(qc[i]), .d(qd[i]),
      .a_o(ra[i]), .b_o(rb[i]), .c_o(rc[i]), .d_o(rd[i])
    );
    assign nxt[i]      = ra[i];
    assign nxt[4 + i]  = diag ? rb[(i + 3) % 4] : rb[i];
    assign nxt[8 + i]  = diag ? rc[(i + 2) % 4] : rc[i];
    assign nxt[12 + i] = diag ? rd[(i + 1) % 4] : rd[i];
  end

  // Initial block state from constants, latched key/nonce and current counter.
  always_comb begin
    init_vec     = '0;
    init_vec[0]  = 32'h61707865;
    init_vec[1]  = 32'h3320646e;
    init_vec[2]  = 32'h79622d32;
    init_vec[3]  = 32'h6b206574;
    for (int w = 0; w < 8; w++) init_vec[4 + w] = le32(key[255 - 32*w -: 32]);
    init_vec[12] = ctr;
    for (int w = 0; w < 3; w++) init_vec[13 + w] = le32(nonce[95 - 32*w -: 32]);
  end

  // Control FSM plus the registered output beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_ctr_wrap <= 1'b0;
      m_valid      <= 1'b0;
      m_last       <= 1'b0;
      m_data       <= '0;
      key          <= '0;
      nonce        <= '0;
      ctr          <= '0;
      blocks_left  <= '0;
      rnd          <= '0;
      beat         <= '0;
      ws           <= '0;
      init_st      <= '0;
    end else begin
      done <= 1'b0;
      if (m_ready) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
      if (xfer) begin
        m_data  <= s_data ^ slice;
        m_valid <= 1'b1;
        // On a wrap abort the current block is the final one.
        m_last  <= last_beat && (!more || ctr == 32'hFFFFFFFF);
      end
      case (state)
        IDLE: begin
          // A pending output beat must drain before a new message starts.
          if (start && !m_valid) begin
            key          <= in_key;
            nonce        <= in_nonce;
            ctr          <= in_counter;
            blocks_left  <= num_blocks;
            err_ctr_wrap <= 1'b0;
            busy         <= 1'b1;
            state        <= (num_blocks == 16'd0) ? DONE : INIT;
          end
        end
        INIT: begin
          ws      <= init_vec;
          init_st <= init_vec;
          rnd     <= '0;
          beat    <= '0;
          state   <= ROUND;
        end
        ROUND: begin
          ws  <= nxt;
          rnd <= rnd + 5'd1;
          if (rnd == 5'(ROUNDS - 1)) state <= FINAL;
        end
        FINAL: begin
          for (int w = 0; w < 16; w++) ws[w] <= ws[w] + init_st[w];
          state <= STREAM;
        end
        STREAM: begin
          if (xfer) begin
            beat <= beat + 5'd1;
            if (last_beat) begin
              if (!more) begin
                state <= DONE;
              end else if (ctr == 32'hFFFFFFFF) begin
                err_ctr_wrap <= 1'b1;
                state        <= DONE;
              end else begin
                ctr         <= ctr + 32'd1;
                blocks_left <= blocks_left - 16'd1;
                state       <= INIT;
              end
            end
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/chacha20_stream_engine.md
Name: chacha20_stream_engine

Overview:
Multi-block ChaCha20 stream cipher engine that sits between a data source and a data sink. It generates consecutive 512-bit keystream blocks with an auto-incrementing 32-bit block counter and XORs them onto a valid/ready data stream. Encryption and decryption are the same operation. It generalises the single-block ChaCha20 core with a parametrised round count, a parametrised beat width, multi-block messages, backpressure and counter-overflow detection.

Parameters:
ROUNDS, 20, total rounds per block; legal values 8, 12, 20 (even, since rounds alternate column/diagonal); other values are an elaboration error.
DATA_W, 32, stream beat width in bits; legal values 32, 64, 128, 256, 512; BEATS = 512/DATA_W.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle request; sampled only in IDLE
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when the message completes
err_ctr_wrap  out  1  sticky until next accepted start; counter overflow
in_key  in  256  key; byte 0 = in_key[255:248]
in_nonce  in  96  nonce; byte 0 = in_nonce[95:88]
in_counter  in  32  initial block counter (numeric)
num_blocks  in  16  blocks in the message; 0 allowed
s_valid  in  1  input beat valid
s_ready  out  1  input beat accepted when s_valid && s_ready
s_data  in  DATA_W  input plaintext/ciphertext beat
m_valid  out  1  output beat valid
m_ready  in  1  sink ready
m_data  out  DATA_W  s_data XOR keystream slice
m_last  out  1  final beat of final block

Behaviour:
- Reset (async, any state): FSM to IDLE. busy, done, err_ctr_wrap, s_ready, m_valid and m_last are 0. m_data and all internal state registers are 0.
- start is accepted in IDLE only and ignored otherwise. On acceptance, key, nonce, counter and num_blocks are latched, err_ctr_wrap is cleared, and busy is set.
- FSM states and transitions:
  - IDLE: on start, go to INIT; if num_blocks == 0, go to DONE.
  - INIT (1 cycle): load the working state and a copy of the initial state.
    - Words 0-3 = 61707865 3320646e 79622d32 6b206574.
    - Words 4-11 = key as little-endian 32-bit words, so RFC key 00..1f gives word4 = 03020100.
    - Word 12 = current counter.
    - Words 13-15 = nonce as little-endian 32-bit words.
  - ROUND (ROUNDS cycles): one round per cycle, with 4 quarter-rounds in parallel. Even-indexed rounds are column rounds and odd-indexed rounds are diagonal rounds. The round counter runs from 0 to ROUNDS-1.
  - FINAL (1 cycle): keystream = working state + initial state, word-wise mod 2^32.
  - STREAM: transfer BEATS beats.
    - After the last beat, if blocks remain and the counter != FFFFFFFF: counter += 1, go to INIT.
    - If blocks remain and the counter == FFFFFFFF: set err_ctr_wrap and go to DONE. No further blocks are generated.
    - Otherwise go to DONE.
  - DONE (1 cycle): done = 1, busy = 0 next cycle, return to IDLE.
- Keystream byte order: keystream byte k is word k/4, bits [8*(k%4)+7 : 8*(k%4)]. Beat b carries bytes b*DATA_W/8 upward, and byte j of the beat sits at bits [8j+7:8j].
- Handshake:
  - s_ready = (state == STREAM) && (!m_valid || m_ready).
  - An input transfer registers m_data = s_data ^ slice and m_valid = 1 on the next edge. Latency is 1 cycle.
  - m_valid clears when m_ready is high with no new input transfer.
  - m_data and m_valid hold stable while m_valid && !m_ready. No beat is lost or duplicated.
  - m_last = 1 with the final beat of the final block. On a wrap abort, m_last is asserted on the last beat of the block in progress.
- Minimum cycles per block: 1 + ROUNDS + 1 + BEATS. No keystream precompute overlap.
- Arithmetic is all mod 2^32. Rotations are 16, 12, 8, 7.
- done may fire while the last m_valid beat is still pending. The sink drains it normally, and the FSM does not leave IDLE on a new start until m_valid == 0.

Test Plan:
- RFC 8439 §2.3.2 vector: key 00..1f, nonce 000000090000004a00000000, counter 1, num_blocks 1, DATA_W=32, s_data=0 on all beats, m_ready=1 -> first m_data = e4e7f110, second = 15593bd1; 16 beats; m_last on beat 16; done pulse.
- Round trip: same key/nonce, 2 blocks of 41424344-pattern plaintext encrypted, ciphertext fed to a second run -> output equals plaintext bit-exact; block 2 uses counter 2.
- Backpressure: random m_ready (50%) and random s_valid gaps -> s_ready is low whenever m_valid && !m_ready; the output sequence is identical to the no-stall run.
- Counter overflow: in_counter = FFFFFFFF, num_blocks = 3 -> exactly one block streamed with m_last on its final beat; err_ctr_wrap = 1; done pulses; err_ctr_wrap clears on the next start.
- num_blocks = 0 -> done pulses 2 cycles after start; m_valid never asserts; s_ready stays 0.
- Reset mid-ROUND (rst high for 1 cycle) -> all outputs at reset values that cycle; a subsequent RFC vector run passes. A ROUNDS=8 elaboration also produces self-consistent round-trip results.
